wb_port_arbiter: RTL and testbench

- Arbitrates the single register-file write port between two sources: the pipeline write-back stage and the multi-cycle multiply/divide unit (MDU).
- MDU results are buffered in a small FIFO and drained on idle write-back cycles.
- A starvation limit and a same-register ordering check force a pipeline stall so the FIFO can drain.
- Sits between the write-back stage and the register file; drives WEN/wsel/wdat.

---
 rtl/wb_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// -----------------------------------------------------------------------------
// wb_port_arbiter
//   Shares the single register-file write port between the pipeline
//   write-back stage and the multiply/divide unit (MDU). MDU results are
//   queued in a small FIFO and drained on cycles where write-back is idle.
//   When the FIFO has gone STARVE_LIMIT cycles without draining, or the
//   pipeline targets a register that still has a queued MDU result, the
//   pipeline is stalled so the FIFO head can be written first.
//
// Ports
//   CLK, nRST        clock (rising edge), asynchronous active-low reset
//   pipe_wen/wsel/wdat   write-back stage request
//   mdu_valid/wsel/wdat  MDU result offered to the FIFO
//   mdu_ready        FIFO can accept an MDU result (registered state only)
//   stall_pipe       hold the pipeline; its write is not performed this cycle
//   WEN/wsel/wdat    register-file write port
// -----------------------------------------------------------------------------
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_wsel,
  input  logic [31:0] pipe_wdat,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_wsel,
  input  logic [31:0] mdu_wdat,
  output logic        mdu_ready,
  output logic        stall_pipe,
  output logic        WEN,
  output logic [4:0]  wsel,
  output logic [31:0] wdat
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    mem_wsel_q [DEPTH];
  logic [31:0]   mem_wdat_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;

  logic pipe_req_s;
  logic empty_s;
  logic full_s;
  logic enq_s;
  logic store_s;
  logic deq_s;
  logic hit_s;

  assign pipe_req_s = pipe_wen && (pipe_wsel != 5'd0);
  assign empty_s    = (count_q == '0);
  assign full_s     = (count_q == DEPTH_C);
  assign mdu_ready  = !full_s;
  assign enq_s      = mdu_valid && !full_s;
  // Results for $0 are accepted (handshake completes) but never stored.
  assign store_s    = enq_s && (mdu_wsel != 5'd0);

  // Same-register check against every occupied FIFO slot.
  always_comb begin
    hit_s = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      hit_s = hit_s | (pipe_req_s && ((AW + 1)'(k) < count_q) &&
                       (mem_wsel_q[rd_ptr_q + AW'(k)] == pipe_wsel));
    end
  end

  // Write-port selection; outputs forced to idle values while in reset.
  always_comb begin
    stall_pipe = 1'b0;
    WEN        = 1'b0;
    wsel       = 5'd0;
    wdat       = 32'd0;
    deq_s      = 1'b0;
    if (!nRST) begin
      deq_s = 1'b0;
    end else if ((state_q == FORCE) || hit_s) begin
      stall_pipe = 1'b1;
      WEN        = 1'b1;
      wsel       = mem_wsel_q[rd_ptr_q];
      wdat       = mem_wdat_q[rd_ptr_q];
      deq_s      = 1'b1;
    end else if (pipe_req_s) begin
      WEN  = 1'b1;
      wsel = pipe_wsel;
      wdat = pipe_wdat;
    end else if (!empty_s) begin
      WEN   = 1'b1;
      wsel  = mem_wsel_q[rd_ptr_q];
      wdat  = mem_wdat_q[rd_ptr_q];
      deq_s = 1'b1;
    end else begin
      deq_s = 1'b0;
    end
  end

  // FIFO pointer/occupancy and starve-counter next state.
  always_comb begin
    rd_ptr_d = deq_s   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = store_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    case ({store_s, deq_s})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    if (deq_s || empty_s) begin
      starve_d = '0;
    end else if (starve_q == STARVE_MAX) begin
      starve_d = starve_q;
    end else begin
      starve_d = starve_q + SW'(1);
    end
  end

  // FSM next state: derived from next occupancy and next starve count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (count_d != '0) ? PEND : IDLE;
      PEND,
      FORCE: begin
        if (count_d == '0) begin
          state_d = IDLE;
        end else if (starve_d == STARVE_MAX) begin
          state_d = FORCE;
        end else begin
          state_d = PEND;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and counter registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // FIFO storage.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_wsel_q[i] <= 5'd0;
        mem_wdat_q[i] <= 32'd0;
      end
    end else if (store_s) begin
      mem_wsel_q[wr_ptr_q] <= mdu_wsel;
      mem_wdat_q[wr_ptr_q] <= mdu_wdat;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pipe_wen;
  logic [4:0]  pipe_wsel;
  logic [31:0] pipe_wdat;
  logic        mdu_valid;
  logic [4:0]  mdu_wsel;
  logic [31:0] mdu_wdat;
  logic        mdu_ready;
  logic        stall_pipe;
  logic        WEN;
  logic [4:0]  wsel;
  logic [31:0] wdat;

  int checks = 0;
  int errors = 0;

  wb_port_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .pipe_wen   (pipe_wen),
    .pipe_wsel  (pipe_wsel),
    .pipe_wdat  (pipe_wdat),
    .mdu_valid  (mdu_valid),
    .mdu_wsel   (mdu_wsel),
    .mdu_wdat   (mdu_wdat),
    .mdu_ready  (mdu_ready),
    .stall_pipe (stall_pipe),
    .WEN        (WEN),
    .wsel       (wsel),
    .wdat       (wdat)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic port(input string tag, input logic en, input logic [4:0] sel,
                      input logic [31:0] dat, input logic stall);
    chk({tag, ".WEN"},   {31'd0, WEN}, {31'd0, en});
    chk({tag, ".wsel"},  {27'd0, wsel}, {27'd0, sel});
    chk({tag, ".wdat"},  wdat, dat);
    chk({tag, ".stall"}, {31'd0, stall_pipe}, {31'd0, stall});
  endtask

  initial begin
    nRST = 1'b0; pipe_wen = 1'b0; pipe_wsel = 5'd0; pipe_wdat = 32'd0;
    mdu_valid = 1'b0; mdu_wsel = 5'd0; mdu_wdat = 32'd0;
    #2;
    port("reset", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("reset.ready", {31'd0, mdu_ready}, 32'd1);
    tick();
    nRST = 1'b1;
    tick();

    // Plain pipeline write
    pipe_wen = 1'b1; pipe_wsel = 5'd5; pipe_wdat = 32'h1234;
    #2;
    port("pipe", 1'b1, 5'd5, 32'h1234, 1'b0);
    chk("pipe.ready", {31'd0, mdu_ready}, 32'd1);
    tick();

    // Single MDU result, drained on the idle cycle after acceptance
    pipe_wen = 1'b0; mdu_valid = 1'b1; mdu_wsel = 5'd8; mdu_wdat = 32'hCAFE;
    #2;
    port("mdu_accept", 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    mdu_valid = 1'b0;
    #2;
    port("mdu_drain", 1'b1, 5'd8, 32'hCAFE, 1'b0);
    tick();
    #2;
    port("mdu_empty", 1'b0, 5'd0, 32'd0, 1'b0);
    tick();

    // Starvation: fill with 9,10 while the pipeline writes every cycle
    pipe_wen = 1'b1; pipe_wsel = 5'd5; pipe_wdat = 32'h55;
    mdu_valid = 1'b1; mdu_wsel = 5'd9; mdu_wdat = 32'h900;
    #2;
    port("starve0", 1'b1, 5'd5, 32'h55, 1'b0);
    tick();
    mdu_wsel = 5'd10; mdu_wdat = 32'hA00;
    #2;
    chk("starve1.ready", {31'd0, mdu_ready}, 32'd1);
    port("starve1", 1'b1, 5'd5, 32'h55, 1'b0);
    tick();
    mdu_valid = 1'b0;
    #2;
    chk("starve2.ready", {31'd0, mdu_ready}, 32'd0);
    port("starve2", 1'b1, 5'd5, 32'h55, 1'b0);
    tick();
    #2;
    port("starve3", 1'b1, 5'd5, 32'h55, 1'b0);
    tick();
    #2;
    port("starve4", 1'b1, 5'd5, 32'h55, 1'b0);
    tick();
    #2;
    port("force", 1'b1, 5'd9, 32'h900, 1'b1);
    chk("force.ready", {31'd0, mdu_ready}, 32'd0);
    tick();
    #2;
    port("after_force", 1'b1, 5'd5, 32'h55, 1'b0);
    chk("after_force.ready", {31'd0, mdu_ready}, 32'd1);
    tick();
    pipe_wen = 1'b0;
    #2;
    port("drain10", 1'b1, 5'd10, 32'hA00, 1'b0);
    tick();
    #2;
    port("drained", 1'b0, 5'd0, 32'd0, 1'b0);

    // Same-register ordering
    mdu_valid = 1'b1; mdu_wsel = 5'd3; mdu_wdat = 32'h333;
    tick();
    mdu_valid = 1'b0; pipe_wen = 1'b1; pipe_wsel = 5'd3; pipe_wdat = 32'h1;
    #2;
    port("hit", 1'b1, 5'd3, 32'h333, 1'b1);
    tick();
    #2;
    port("hit_after", 1'b1, 5'd3, 32'h1, 1'b0);
    tick();

    // Register $0 from both sources
    pipe_wsel = 5'd0; pipe_wdat = 32'hDEAD;
    mdu_valid = 1'b1; mdu_wsel = 5'd0; mdu_wdat = 32'hBEEF;
    #2;
    port("zero_pipe", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("zero.ready", {31'd0, mdu_ready}, 32'd1);
    tick();
    mdu_valid = 1'b0; pipe_wen = 1'b0;
    #2;
    port("zero_drop", 1'b0, 5'd0, 32'd0, 1'b0);
    tick();
    #2;
    port("zero_drop2", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("zero_drop2.ready", {31'd0, mdu_ready}, 32'd1);

    // Reset mid-operation with two entries buffered
    pipe_wen = 1'b1; pipe_wsel = 5'd5; pipe_wdat = 32'h77;
    mdu_valid = 1'b1; mdu_wsel = 5'd11; mdu_wdat = 32'hB00;
    tick();
    mdu_wsel = 5'd12; mdu_wdat = 32'hC00;
    tick();
    mdu_valid = 1'b0;
    #2;
    chk("pre_rst.ready", {31'd0, mdu_ready}, 32'd0);
    nRST = 1'b0;
    #1;
    port("mid_rst", 1'b0, 5'd0, 32'd0, 1'b0);
    chk("mid_rst.ready", {31'd0, mdu_ready}, 32'd1);
    tick();
    nRST = 1'b1; pipe_wen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      port("post_rst", 1'b0, 5'd0, 32'd0, 1'b0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
